neurotransmitter_hub: RTL and testbench

Downstream consumer of the per-transmitter 2-bit level outputs (dopamine, serotonin, cortisol, GABA, norepinephrine). It filters each level through a persistence (debounce) and slew stage, then packs the filtered levels into the 10-bit neurotransmitter_level bus that the regulators consume. Filtering stops resource dithering around a quantisation boundary from toggling regulator decisions every tick. It also emits per-channel change strobes for the emotion logic.

---
 rtl/neurotransmitter_hub_if.sv | 25 ++
 rtl/neurotransmitter_hub.sv | 112 +++++++++++
 tb/tb_neurotransmitter_hub.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/neurotransmitter_hub_if.sv
// Bundles the raw level inputs, the tick enable and the filtered outputs
// exchanged between the level producers/consumers and the hub.
interface neurotransmitter_hub_if;
   logic       tick;
   logic [1:0] dopamine_level;
   logic [1:0] serotonin_level;
   logic [1:0] cortisol_level;
   logic [1:0] gaba_level;
   logic [1:0] norepinephrine_level;
   logic [9:0] neurotransmitter_level;
   logic [4:0] changed_mask;
   logic       level_changed;

   modport master (
      output tick, dopamine_level, serotonin_level, cortisol_level,
             gaba_level, norepinephrine_level,
      input  neurotransmitter_level, changed_mask, level_changed
   );

   modport slave (
      input  tick, dopamine_level, serotonin_level, cortisol_level,
             gaba_level, norepinephrine_level,
      output neurotransmitter_level, changed_mask, level_changed
   );
endinterface

// File: rtl/neurotransmitter_hub.sv
// Neurotransmitter hub: debounces and slew-limits each 2-bit transmitter
// level so that dithering around a quantisation boundary cannot toggle the
// regulators, then packs the filtered levels and flags per-channel commits.

// One channel: filtered level F, candidate C and persistence counter N.
module nt_chan_filter #(
   parameter int HOLD_TICKS  = 4,
   parameter int SLEW_LIMIT  = 1,
   parameter int RESET_LEVEL = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [1:0] raw,
   output logic [1:0] filt,
   output logic       commit_nxt,
   output logic       commit
);
   localparam int             CW     = $clog2(HOLD_TICKS + 1);
   localparam logic [CW-1:0]  HOLD_N = CW'(HOLD_TICKS);
   localparam logic [1:0]     RST_LV = 2'(RESET_LEVEL);

   logic [1:0]    cand, cand_d, filt_d;
   logic [CW-1:0] cnt, cnt_d, cnt_inc;

   // Next-state: count consecutive enabled ticks of a stable differing input,
   // commit one step (or a direct jump) once the count reaches HOLD_TICKS.
   always_comb begin
      filt_d     = filt;
      cand_d     = cand;
      cnt_d      = cnt;
      commit_nxt = 1'b0;
      cnt_inc    = (raw == cand) ? cnt + CW'(1) : CW'(1);
      if (tick) begin
         cand_d = raw;
         if (raw == filt) begin
            cnt_d = '0;
         end else if (cnt_inc == HOLD_N) begin
            commit_nxt = 1'b1;
            cnt_d      = '0;
            if (SLEW_LIMIT != 0)
               filt_d = (raw > filt) ? filt + 2'd1 : filt - 2'd1;
            else
               filt_d = raw;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   // Channel state registers; reset discards any partial count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt   <= RST_LV;
         cand   <= RST_LV;
         cnt    <= '0;
         commit <= 1'b0;
      end else begin
         filt   <= filt_d;
         cand   <= cand_d;
         cnt    <= cnt_d;
         commit <= commit_nxt;
      end
   end
endmodule

module neurotransmitter_hub #(
   parameter int HOLD_TICKS  = 4,
   parameter int SLEW_LIMIT  = 1,
   parameter int RESET_LEVEL = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   neurotransmitter_hub_if.slave hub
);
   localparam int NUM_LANES = 5;

   logic [NUM_LANES-1:0][1:0] raw, filt;
   logic [NUM_LANES-1:0]      commit_nxt, commit_q;
   logic                      lc_q;

   // Lane order matches the output packing, dopamine in the low bits.
   assign raw = {hub.norepinephrine_level, hub.gaba_level, hub.cortisol_level,
                 hub.serotonin_level, hub.dopamine_level};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      nt_chan_filter #(
         .HOLD_TICKS (HOLD_TICKS),
         .SLEW_LIMIT (SLEW_LIMIT),
         .RESET_LEVEL(RESET_LEVEL)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .tick      (hub.tick),
         .raw       (raw[i]),
         .filt      (filt[i]),
         .commit_nxt(commit_nxt[i]),
         .commit    (commit_q[i])
      );
   end

   // Summary strobe registered from the same next-commit terms as the mask,
   // so it pulses in exactly the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) lc_q <= 1'b0;
      else        lc_q <= |commit_nxt;
   end

   assign hub.neurotransmitter_level = filt;
   assign hub.changed_mask           = commit_q;
   assign hub.level_changed          = lc_q;
endmodule

// File: tb/tb_neurotransmitter_hub.sv
// Bench for neurotransmitter_hub: a slewing DUT (defaults) and a jumping DUT
// (SLEW_LIMIT=0) share stimulus; a streak-counting model predicts both.
module tb_neurotransmitter_hub;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic [9:0] lv;

   always #5 clk = ~clk;

   neurotransmitter_hub_if ifa ();
   neurotransmitter_hub_if ifb ();

   assign ifa.tick = tick;
   assign ifa.dopamine_level       = lv[1:0];
   assign ifa.serotonin_level      = lv[3:2];
   assign ifa.cortisol_level       = lv[5:4];
   assign ifa.gaba_level           = lv[7:6];
   assign ifa.norepinephrine_level = lv[9:8];
   assign ifb.tick = tick;
   assign ifb.dopamine_level       = lv[1:0];
   assign ifb.serotonin_level      = lv[3:2];
   assign ifb.cortisol_level       = lv[5:4];
   assign ifb.gaba_level           = lv[7:6];
   assign ifb.norepinephrine_level = lv[9:8];

   neurotransmitter_hub dut_a (.clk(clk), .rst_n(rst_n), .hub(ifa));
   neurotransmitter_hub #(.HOLD_TICKS(4), .SLEW_LIMIT(0), .RESET_LEVEL(2))
      dut_b (.clk(clk), .rst_n(rst_n), .hub(ifb));

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int hold[2] = '{4, 4};
   int slew[2] = '{1, 0};
   int mf[2][5];      // filtered level
   int mlast[2][5];   // last value seen on an enabled tick
   int streak[2][5];  // consecutive enabled ticks of that differing value
   int emask[2];
   int elc[2];
   bit armed = 1'b0;

   function automatic int lvl(int ch);
      return int'((lv >> (2 * ch)) & 10'h3);
   endfunction

   function automatic int exp_nt(int k);
      int r = 0;
      for (int ch = 0; ch < 5; ch++) r |= mf[k][ch] << (2 * ch);
      return r;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            for (int ch = 0; ch < 5; ch++) begin
               mf[k][ch] = 2; mlast[k][ch] = 2; streak[k][ch] = 0;
            end
            emask[k] = 0; elc[k] = 0;
            armed = 1'b1;
         end else if (!tick) begin
            emask[k] = 0; elc[k] = 0;
         end else begin
            emask[k] = 0;
            for (int ch = 0; ch < 5; ch++) begin
               if (lvl(ch) == mf[k][ch]) begin
                  streak[k][ch] = 0;
               end else begin
                  streak[k][ch] = (lvl(ch) == mlast[k][ch]) ? streak[k][ch] + 1 : 1;
                  if (streak[k][ch] == hold[k]) begin
                     if (slew[k] != 0) mf[k][ch] += (lvl(ch) > mf[k][ch]) ? 1 : -1;
                     else              mf[k][ch] = lvl(ch);
                     streak[k][ch] = 0;
                     emask[k] |= 1 << ch;
                  end
               end
               mlast[k][ch] = lvl(ch);
            end
            elc[k] = (emask[k] != 0) ? 1 : 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (armed) begin
         chk("a_level", 32'(ifa.neurotransmitter_level), exp_nt(0));
         chk("a_mask",  32'(ifa.changed_mask),           emask[0]);
         chk("a_lc",    32'(ifa.level_changed),          elc[0]);
         chk("b_level", 32'(ifb.neurotransmitter_level), exp_nt(1));
         chk("b_mask",  32'(ifb.changed_mask),           emask[1]);
         chk("b_lc",    32'(ifb.level_changed),          elc[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit tk, input logic [9:0] v);
      @(negedge clk);
      rst_n = 1'b1; tick = tk; lv = v;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; tick = 1'b1;
      @(posedge clk); #1;
      chk("rst_level", 32'(ifa.neurotransmitter_level), 32'h2AA);
      chk("rst_mask",  32'(ifa.changed_mask), 0);
      chk("rst_lc",    32'(ifa.level_changed), 0);
   endtask

   logic [1:0] cur[5];

   initial begin
      rst_n = 1'b0; tick = 1'b0; lv = 10'h2AA;

      // 1: dopamine 2->3 commits on the 4th tick, one-cycle pulse
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1, 10'h2AB);
         chk("t1_hold", 32'(ifa.neurotransmitter_level), 32'h2AA);
      end
      step(1, 10'h2AB);
      chk("t1_level", 32'(ifa.neurotransmitter_level), 32'h2AB);
      chk("t1_mask",  32'(ifa.changed_mask), 32'h01);
      chk("t1_lc",    32'(ifa.level_changed), 1);
      step(1, 10'h2AB);
      chk("t1_mask_off", 32'(ifa.changed_mask), 0);
      chk("t1_lc_off",   32'(ifa.level_changed), 0);

      // 2: cortisol glitches never persist long enough
      do_reset();
      repeat (3) step(1, 10'h2BA);
      step(1, 10'h2AA);
      chk("t2_glitch", 32'(ifa.neurotransmitter_level), 32'h2AA);
      repeat (3) step(1, 10'h2BA);
      step(1, 10'h28A);
      repeat (3) step(1, 10'h2BA);
      chk("t2_restart_a", 32'(ifa.neurotransmitter_level), 32'h2AA);
      chk("t2_restart_b", 32'(ifb.neurotransmitter_level), 32'h2AA);

      // 3: serotonin 2->0, slew steps twice vs jump once
      do_reset();
      repeat (4) step(1, 10'h2A2);
      chk("t3_slew1", 32'(ifa.neurotransmitter_level), 32'h2A6);
      chk("t3_jump",  32'(ifb.neurotransmitter_level), 32'h2A2);
      chk("t3_maskb", 32'(ifb.changed_mask), 32'h02);
      repeat (4) step(1, 10'h2A2);
      chk("t3_slew2", 32'(ifa.neurotransmitter_level), 32'h2A2);
      chk("t3_maska", 32'(ifa.changed_mask), 32'h02);
      repeat (5) step(1, 10'h2A2);
      chk("t3_settled", 32'(ifa.neurotransmitter_level), 32'h2A2);

      // 4: GABA 2->1 with tick alternating; commit on the 4th enabled tick
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(i % 2 == 0, 10'h26A);
         if (i == 5) chk("t4_before", 32'(ifa.neurotransmitter_level), 32'h2AA);
      end
      chk("t4_level", 32'(ifa.neurotransmitter_level), 32'h26A);
      chk("t4_mask",  32'(ifa.changed_mask), 32'h08);

      // 5: reset mid-count discards the partial count
      do_reset();
      repeat (3) step(1, 10'h3AA);
      do_reset();
      repeat (3) step(1, 10'h3AA);
      chk("t5_hold",  32'(ifa.neurotransmitter_level), 32'h2AA);
      step(1, 10'h3AA);
      chk("t5_level", 32'(ifa.neurotransmitter_level), 32'h3AA);
      chk("t5_mask",  32'(ifa.changed_mask), 32'h10);

      // 6: all channels commit together
      do_reset();
      repeat (4) step(1, 10'h3FF);
      chk("t6_level_a", 32'(ifa.neurotransmitter_level), 32'h3FF);
      chk("t6_level_b", 32'(ifb.neurotransmitter_level), 32'h3FF);
      chk("t6_mask",    32'(ifa.changed_mask), 32'h1F);
      chk("t6_lc",      32'(ifa.level_changed), 1);

      // Random: sticky per-channel levels so streaks form, sparse resets
      for (int ch = 0; ch < 5; ch++) cur[ch] = 2'd3;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         rst_n = ($urandom_range(99) != 0);
         tick  = ($urandom_range(3) != 0);
         for (int ch = 0; ch < 5; ch++)
            if ($urandom_range(5) == 0) cur[ch] = 2'($urandom_range(3));
         lv = {cur[4], cur[3], cur[2], cur[1], cur[0]};
      end
      @(negedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
